serial_subtractor: RTL and testbench

- Parametrised multi-cycle subtractor; the sequential successor of the single-bit half subtractor.
- Computes diff = a - b - borrow_in on WIDTH-bit unsigned operands, DIGIT bits per clock, with a registered borrow chain.
- Operand intake and result delivery each use a valid/ready handshake.
- Sits in the arithmetic datapath wherever area matters more than latency.

---
 rtl/sub_pkg.sv | 29 ++
 rtl/digit_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 168 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// counter width helper used to size the digit counter.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; never less than one so a counter always exists.
  function automatic int clog2(input int n);
    int v;
    int r;
    v = n - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit subtractor with borrow in and borrow out: the
// half/full subtractor widened to one digit of the serial datapath.
module digit_subtractor #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] diff,
  output logic             borrow_out
);

  logic [DIGIT:0] full_s;

  // One extra bit captures the sign of the digit result, which is the borrow.
  always_comb begin
    full_s = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, borrow_in};
  end

  assign diff       = full_s[DIGIT-1:0];
  assign borrow_out = full_s[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, DIGIT bits per clock,
// least significant digit first, with valid/ready on intake and result.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             brw_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             borrow_out_r;
  logic             ovf_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [DIGIT-1:0] d_s;
  logic             bout_s;
  logic [WIDTH-1:0] diff_next_s;
  logic             accept_s;
  logic             last_s;

  digit_subtractor #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a         (a_sh_r[DIGIT-1:0]),
    .b         (b_sh_r[DIGIT-1:0]),
    .borrow_in (brw_r),
    .diff      (d_s),
    .borrow_out(bout_s)
  );

  // Decode handshake events and form the shifted result with the new digit on top.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && in_ready_r && in_valid;
    last_s      = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    diff_next_s = (diff_r >> DIGIT) | (WIDTH'(d_s) << (WIDTH - DIGIT));
  end

  // Next-state logic; in_ready gates acceptance so the first cycle after reset is quiet.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake flags are registered from the next state so they track it without decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, digit-serial subtraction and final flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      brw_r        <= 1'b0;
      cnt_r        <= '0;
      diff_r       <= '0;
      a_msb_r      <= 1'b0;
      b_msb_r      <= 1'b0;
      borrow_out_r <= 1'b0;
      ovf_r        <= 1'b0;
      zero_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            brw_r   <= borrow_in;
            cnt_r   <= '0;
            // Sign bits are kept aside because the operand registers shift away.
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
          end
        end
        ST_RUN: begin
          a_sh_r <= a_sh_r >> DIGIT;
          b_sh_r <= b_sh_r >> DIGIT;
          brw_r  <= bout_s;
          diff_r <= diff_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            borrow_out_r <= bout_s;
            ovf_r        <= (a_msb_r != b_msb_r) && (diff_next_s[WIDTH-1] != a_msb_r);
            zero_r       <= ~|diff_next_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign ovf        = ovf_r;
  assign zero       = zero_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: four instances (16/4, 8/1, 8/8, 32/4) share operand
// buses; each scenario drives one instance and compares against a plain
// arithmetic model of a - b - borrow_in.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic        bin_bus;
  logic [3:0]  in_valid_v;
  logic [3:0]  out_ready_v;
  logic [3:0]  in_ready_v;
  logic [3:0]  out_valid_v;
  logic [3:0]  borrow_v;
  logic [3:0]  ovf_v;
  logic [3:0]  zero_v;
  logic [31:0] diff_v [4];

  logic [15:0] diff16;
  logic [7:0]  diff8a;
  logic [7:0]  diff8b;
  logic [31:0] diff32;

  int pass_cnt;
  int total_cnt;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_bus[15:0]), .b(b_bus[15:0]), .borrow_in(bin_bus),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .diff(diff16),
    .borrow_out(borrow_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .borrow_in(bin_bus),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .diff(diff8a),
    .borrow_out(borrow_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .borrow_in(bin_bus),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .diff(diff8b),
    .borrow_out(borrow_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .a(a_bus), .b(b_bus), .borrow_in(bin_bus),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .diff(diff32),
    .borrow_out(borrow_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3])
  );

  assign diff_v[0] = {16'd0, diff16};
  assign diff_v[1] = {24'd0, diff8a};
  assign diff_v[2] = {24'd0, diff8b};
  assign diff_v[3] = diff32;

  function automatic int width_of(input int k);
    case (k)
      0:       return 16;
      1:       return 8;
      2:       return 8;
      3:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int steps_of(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference: modular difference, unsigned borrow and the sign-bit overflow rule.
  function automatic void ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                    input logic bin, output logic [31:0] d, output logic bo,
                                    output logic ov, output logic z);
    longint unsigned mask;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned ud;
    bit sa;
    bit sb;
    bit sd;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, av} & mask;
    ub   = {32'd0, bv} & mask;
    ud   = (ua - ub - {63'd0, bin}) & mask;
    bo   = (ua < ub + {63'd0, bin});
    sa   = ((ua >> (w - 1)) & 64'd1) != 64'd0;
    sb   = ((ub >> (w - 1)) & 64'd1) != 64'd0;
    sd   = ((ud >> (w - 1)) & 64'd1) != 64'd0;
    ov   = (sa != sb) && (sd != sa);
    z    = (ud == 64'd0);
    d    = ud[31:0];
  endfunction

  // One complete transaction on instance k with out_ready held high.
  task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic bin, input string tag);
    logic [31:0] exp_d;
    logic        exp_bo;
    logic        exp_ov;
    logic        exp_z;
    int          edges;
    ref_model(width_of(k), av, bv, bin, exp_d, exp_bo, exp_ov, exp_z);
    @(negedge clk);
    total_cnt++;
    if (in_ready_v[k] !== 1'b1) $display("FAIL %s.in_ready_idle[%0d]: got %b expected 1", tag, k, in_ready_v[k]);
    else pass_cnt++;
    a_bus = av; b_bus = bv; bin_bus = bin;
    in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    edges = 1;
    while (out_valid_v[k] !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    total_cnt++;
    if (edges !== steps_of(k) + 1) $display("FAIL %s.latency[%0d]: got %0d edges expected %0d", tag, k, edges, steps_of(k) + 1);
    else pass_cnt++;
    total_cnt++;
    if (diff_v[k] !== exp_d) $display("FAIL %s.diff[%0d]: a=%h b=%h bin=%b got %h expected %h", tag, k, av, bv, bin, diff_v[k], exp_d);
    else pass_cnt++;
    total_cnt++;
    if (borrow_v[k] !== exp_bo) $display("FAIL %s.borrow_out[%0d]: a=%h b=%h got %b expected %b", tag, k, av, bv, borrow_v[k], exp_bo);
    else pass_cnt++;
    total_cnt++;
    if (ovf_v[k] !== exp_ov) $display("FAIL %s.ovf[%0d]: a=%h b=%h got %b expected %b", tag, k, av, bv, ovf_v[k], exp_ov);
    else pass_cnt++;
    total_cnt++;
    if (zero_v[k] !== exp_z) $display("FAIL %s.zero[%0d]: a=%h b=%h got %b expected %b", tag, k, av, bv, zero_v[k], exp_z);
    else pass_cnt++;
    total_cnt++;
    if (in_ready_v[k] !== 1'b0) $display("FAIL %s.in_ready_done[%0d]: got %b expected 0", tag, k, in_ready_v[k]);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid_v[k] !== 1'b0) $display("FAIL %s.out_valid_after_hs[%0d]: got %b expected 0", tag, k, out_valid_v[k]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_bus = 32'd0; b_bus = 32'd0; bin_bus = 1'b0;
    in_valid_v = 4'b0000; out_ready_v = 4'b1111;
    #2;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({in_ready_v[k], out_valid_v[k], borrow_v[k], ovf_v[k], zero_v[k]} !== 5'b00000 || diff_v[k] !== 32'd0)
        $display("FAIL reset.outputs[%0d]: got rdy=%b vld=%b bo=%b ov=%b z=%b diff=%h expected all 0",
                 k, in_ready_v[k], out_valid_v[k], borrow_v[k], ovf_v[k], zero_v[k], diff_v[k]);
      else pass_cnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (in_ready_v[k] !== 1'b1) $display("FAIL reset.in_ready_after[%0d]: got %b expected 1", k, in_ready_v[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    run_op(0, 32'h1234, 32'h0234, 1'b0, "basic");
    run_op(0, 32'h0000, 32'h0001, 1'b0, "underflow");
    run_op(0, 32'h00FF, 32'h00FE, 1'b1, "zero");
    run_op(0, 32'h8000, 32'h0001, 1'b0, "ovf_neg");
    run_op(0, 32'h7FFF, 32'hFFFF, 1'b0, "ovf_pos");
    run_op(0, 32'hFFFF, 32'hFFFF, 1'b1, "all_ones_bin");
  endtask

  task automatic test_backpressure();
    int edges;
    @(negedge clk);
    a_bus = 32'hABCD; b_bus = 32'h1234; bin_bus = 1'b0;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
    @(posedge clk); #1;
    edges = 1;
    // New operands offered while the first operation is running.
    a_bus = 32'h0000; b_bus = 32'hFFFF; bin_bus = 1'b1;
    while (out_valid_v[0] !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      in_valid_v[0] = (edges < 3) ? 1'b1 : 1'b0;
    end
    total_cnt++;
    if (edges !== 5) $display("FAIL bp.latency: got %0d edges expected 5", edges);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_v[0] = i[0];
      a_bus = 32'h5555 + 32'(i); b_bus = 32'h0101;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid_v[0] !== 1'b1) $display("FAIL bp.out_valid_hold[%0d]: got %b expected 1", i, out_valid_v[0]);
      else pass_cnt++;
      total_cnt++;
      if (diff_v[0] !== 32'h9999) $display("FAIL bp.diff_hold[%0d]: got %h expected 00009999", i, diff_v[0]);
      else pass_cnt++;
      total_cnt++;
      if (in_ready_v[0] !== 1'b0) $display("FAIL bp.in_ready_hold[%0d]: got %b expected 0", i, in_ready_v[0]);
      else pass_cnt++;
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0; out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1)
      $display("FAIL bp.release: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid_v[0], in_ready_v[0]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int edges;
    int prev;
    int results;
    @(negedge clk);
    a_bus = 32'h0F0F; b_bus = 32'h00FF; bin_bus = 1'b1;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    edges = 0; prev = -1; results = 0;
    while (results < 3 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid_v[0] === 1'b1) begin
        total_cnt++;
        if (diff_v[0] !== 32'h0E0F) $display("FAIL b2b.diff[%0d]: got %h expected 00000e0f", results, diff_v[0]);
        else pass_cnt++;
        if (prev >= 0) begin
          total_cnt++;
          if (edges - prev !== 6) $display("FAIL b2b.period[%0d]: got %0d expected 6", results, edges - prev);
          else pass_cnt++;
        end
        prev = edges;
        results++;
        if (results == 3) in_valid_v[0] = 1'b0;
      end
    end
    in_valid_v[0] = 1'b0;
    total_cnt++;
    if (results !== 3) $display("FAIL b2b.count: got %0d results expected 3", results);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a_bus = 32'h4321; b_bus = 32'h1111; bin_bus = 1'b0;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready_v[0], out_valid_v[0], borrow_v[0], ovf_v[0], zero_v[0]} !== 5'b00000 || diff_v[0] !== 32'd0)
      $display("FAIL rst_mid.outputs: got rdy=%b vld=%b bo=%b ov=%b z=%b diff=%h expected all 0",
               in_ready_v[0], out_valid_v[0], borrow_v[0], ovf_v[0], zero_v[0], diff_v[0]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready_v[0] !== 1'b1) $display("FAIL rst_mid.in_ready: got %b expected 1", in_ready_v[0]);
    else pass_cnt++;
    run_op(0, 32'h0005, 32'h0003, 1'b0, "rst_recover");
  endtask

  task automatic test_random(input int k, input int count);
    logic [31:0] mask;
    logic [31:0] av;
    logic [31:0] bv;
    logic        bin;
    mask = (width_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_of(k)) - 32'd1);
    for (int i = 0; i < count; i++) begin
      av  = $urandom & mask;
      bv  = $urandom & mask;
      bin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       bv = av;
        1:       av = 32'd0;
        2:       bv = mask;
        default: bv = bv;
      endcase
      run_op(k, av, bv, bin, "random");
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    test_random(3, 1000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
